// File: rtl/alu_exec_unit.sv
// Two-stage RV32I integer execute unit: S1 latches the issued op, S2 computes
// the result/branch outcome and registers the common-data broadcast.
module alu_exec_unit #(
    parameter int ROB_W = 4,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             in_config,
    input  logic [XLEN-1:0]  in_value_1,
    input  logic [XLEN-1:0]  in_value_2,
    input  logic [XLEN-1:0]  in_value_pc,
    input  logic [6:0]       in_opcode,
    input  logic [2:0]       in_precise,
    input  logic             in_more_precise,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [ROB_W-1:0] in_rob_entry,
    output logic             out_config,
    output logic [XLEN-1:0]  out_val,
    output logic [ROB_W-1:0] out_rob_entry,
    output logic             out_is_branch,
    output logic             out_taken,
    output logic [XLEN-1:0]  out_target_pc
);

    typedef enum logic [6:0] {
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_BRANCH = 7'b1100011,
        OPC_OPIMM  = 7'b0010011,
        OPC_OP     = 7'b0110011
    } opcode_e;

    logic             s1_valid_q;
    logic [XLEN-1:0]  s1_v1_q, s1_v2_q, s1_pc_q, s1_imm_q;
    logic [6:0]       s1_opcode_q;
    logic [2:0]       s1_funct3_q;
    logic             s1_alt_q;
    logic [ROB_W-1:0] s1_rob_q;

    logic             out_config_q;
    logic [XLEN-1:0]  out_val_q, out_target_q;
    logic [ROB_W-1:0] out_rob_q;
    logic             out_branch_q, out_taken_q;

    logic [XLEN-1:0]  val_d, target_d, pc4, op_b, jalr_sum;
    logic             branch_d, taken_d, cond;
    logic [4:0]       shamt;

    always_comb begin
        val_d    = '0;
        branch_d = 1'b0;
        taken_d  = 1'b0;
        cond     = 1'b0;
        pc4      = s1_pc_q + XLEN'(4);
        target_d = pc4;
        jalr_sum = s1_v1_q + s1_imm_q;
        op_b     = (s1_opcode_q == OPC_OP) ? s1_v2_q : s1_imm_q;
        shamt    = op_b[4:0];
        case (s1_opcode_q)
            OPC_LUI:   val_d = s1_imm_q;
            OPC_AUIPC: val_d = s1_pc_q + s1_imm_q;
            OPC_JAL: begin
                val_d    = pc4;
                branch_d = 1'b1;
                taken_d  = 1'b1;
                target_d = s1_pc_q + s1_imm_q;
            end
            OPC_JALR: begin
                val_d    = pc4;
                branch_d = 1'b1;
                taken_d  = 1'b1;
                target_d = {jalr_sum[XLEN-1:1], 1'b0};
            end
            OPC_BRANCH: begin
                case (s1_funct3_q)
                    3'b000:  cond = (s1_v1_q == s1_v2_q);
                    3'b001:  cond = (s1_v1_q != s1_v2_q);
                    3'b100:  cond = ($signed(s1_v1_q) < $signed(s1_v2_q));
                    3'b101:  cond = ($signed(s1_v1_q) >= $signed(s1_v2_q));
                    3'b110:  cond = (s1_v1_q < s1_v2_q);
                    3'b111:  cond = (s1_v1_q >= s1_v2_q);
                    default: cond = 1'b0;
                endcase
                branch_d = 1'b1;
                taken_d  = cond;
                target_d = cond ? (s1_pc_q + s1_imm_q) : pc4;
            end
            OPC_OPIMM, OPC_OP: begin
                case (s1_funct3_q)
                    3'b000: begin
                        if (s1_opcode_q == OPC_OP && s1_alt_q) val_d = s1_v1_q - op_b;
                        else                                   val_d = s1_v1_q + op_b;
                    end
                    3'b001: val_d = s1_v1_q << shamt;
                    3'b010: val_d = {{(XLEN-1){1'b0}}, ($signed(s1_v1_q) < $signed(op_b))};
                    3'b011: val_d = {{(XLEN-1){1'b0}}, (s1_v1_q < op_b)};
                    3'b100: val_d = s1_v1_q ^ op_b;
                    // Separate branches keep the arithmetic shift out of an unsigned ternary.
                    3'b101: begin
                        if (s1_alt_q) val_d = $signed(s1_v1_q) >>> shamt;
                        else          val_d = s1_v1_q >> shamt;
                    end
                    3'b110: val_d = s1_v1_q | op_b;
                    default: val_d = s1_v1_q & op_b;
                endcase
            end
            default: val_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            out_config_q <= 1'b0;
            out_val_q    <= '0;
            out_rob_q    <= '0;
            out_branch_q <= 1'b0;
            out_taken_q  <= 1'b0;
            out_target_q <= '0;
        end else if (rollback) begin
            s1_valid_q   <= 1'b0;
            out_config_q <= 1'b0;
        end else if (rdy) begin
            s1_valid_q <= in_config;
            if (in_config) begin
                s1_v1_q     <= in_value_1;
                s1_v2_q     <= in_value_2;
                s1_pc_q     <= in_value_pc;
                s1_imm_q    <= in_imm;
                s1_opcode_q <= in_opcode;
                s1_funct3_q <= in_precise;
                s1_alt_q    <= in_more_precise;
                s1_rob_q    <= in_rob_entry;
            end
            out_config_q <= s1_valid_q;
            if (s1_valid_q) begin
                out_val_q    <= val_d;
                out_rob_q    <= s1_rob_q;
                out_branch_q <= branch_d;
                out_taken_q  <= taken_d;
                out_target_q <= target_d;
            end
        end
    end

    assign out_config    = out_config_q;
    assign out_val       = out_val_q;
    assign out_rob_entry = out_rob_q;
    assign out_is_branch = out_branch_q;
    assign out_taken     = out_taken_q;
    assign out_target_pc = out_target_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized traffic
// against a behavioural RV32I execute model with an issue/broadcast scoreboard.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst, rdy, rollback, in_config;
    logic [31:0] in_value_1, in_value_2, in_value_pc, in_imm;
    logic [6:0]  in_opcode;
    logic [2:0]  in_precise;
    logic        in_more_precise;
    logic [3:0]  in_rob_entry;
    logic        out_config, out_is_branch, out_taken;
    logic [31:0] out_val, out_target_pc;
    logic [3:0]  out_rob_entry;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    alu_exec_unit #(.ROB_W(4), .XLEN(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .in_config(in_config),
        .in_value_1(in_value_1), .in_value_2(in_value_2), .in_value_pc(in_value_pc),
        .in_opcode(in_opcode), .in_precise(in_precise), .in_more_precise(in_more_precise),
        .in_imm(in_imm), .in_rob_entry(in_rob_entry),
        .out_config(out_config), .out_val(out_val), .out_rob_entry(out_rob_entry),
        .out_is_branch(out_is_branch), .out_taken(out_taken), .out_target_pc(out_target_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] v1, v2, pc, imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        mp;
        logic [3:0]  rob;
    } op_t;

    typedef struct packed {
        logic        cfg;
        logic [31:0] val;
        logic [3:0]  rob;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
    } res_t;

    logic pend_v;
    op_t  pend;
    res_t exp_o;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Architectural meaning of each op, written from the ISA rules.
    function automatic res_t ref_exec(input op_t o);
        res_t r;
        logic [31:0] a, b;
        int sa, sb;
        longint unsigned ua, ub;
        int unsigned sh;
        r = '0;
        r.cfg = 1'b1;
        r.rob = o.rob;
        r.tgt = o.pc + 32'd4;
        a = o.v1;
        b = (o.opc == 7'b0110011) ? o.v2 : o.imm;
        if (o.opc == 7'b1100011) b = o.v2;
        sa = a; sb = b; ua = a; ub = b;
        sh = b % 32;
        case (o.opc)
            7'b0110111: r.val = o.imm;
            7'b0010111: r.val = o.pc + o.imm;
            7'b1101111: begin r.val = o.pc + 32'd4; r.br = 1; r.tk = 1; r.tgt = o.pc + o.imm; end
            7'b1100111: begin
                r.val = o.pc + 32'd4; r.br = 1; r.tk = 1;
                r.tgt = (o.v1 + o.imm) & 32'hFFFF_FFFE;
            end
            7'b1100011: begin
                r.br = 1;
                case (o.f3)
                    3'd0: r.tk = (ua == ub);
                    3'd1: r.tk = (ua != ub);
                    3'd4: r.tk = (sa < sb);
                    3'd5: r.tk = (sa >= sb);
                    3'd6: r.tk = (ua < ub);
                    3'd7: r.tk = (ua >= ub);
                    default: r.tk = 0;
                endcase
                if (r.tk) r.tgt = o.pc + o.imm;
            end
            7'b0010011, 7'b0110011: begin
                case (o.f3)
                    3'd0: r.val = (o.opc == 7'b0110011 && o.mp) ? a - b : a + b;
                    3'd1: r.val = a << sh;
                    3'd2: r.val = (sa < sb) ? 32'd1 : 32'd0;
                    3'd3: r.val = (ua < ub) ? 32'd1 : 32'd0;
                    3'd4: r.val = a ^ b;
                    3'd5: r.val = (a >> sh) | ((o.mp && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
                    3'd6: r.val = a | b;
                    default: r.val = a & b;
                endcase
            end
            default: r.val = 0;
        endcase
        return r;
    endfunction

    // Advance one clock: update the scoreboard from what the DUT sees at the edge,
    // then compare every output on the following falling edge.
    task automatic tick();
        op_t c;
        c = '{v1: in_value_1, v2: in_value_2, pc: in_value_pc, imm: in_imm, opc: in_opcode,
              f3: in_precise, mp: in_more_precise, rob: in_rob_entry};
        if (rst) begin
            pend_v = 0;
            exp_o  = '0;
        end else if (rollback) begin
            pend_v    = 0;
            exp_o.cfg = 0;
        end else if (rdy) begin
            if (pend_v) exp_o = ref_exec(pend);
            else        exp_o.cfg = 0;
            pend_v = in_config;
            pend   = c;
        end
        @(posedge clk);
        @(negedge clk);
        check_eq("cfg", {31'd0, out_config}, {31'd0, exp_o.cfg});
        check_eq("val", out_val, exp_o.val);
        check_eq("rob", {28'd0, out_rob_entry}, {28'd0, exp_o.rob});
        check_eq("is_branch", {31'd0, out_is_branch}, {31'd0, exp_o.br});
        check_eq("taken", {31'd0, out_taken}, {31'd0, exp_o.tk});
        check_eq("target", out_target_pc, exp_o.tgt);
    endtask

    task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic mp,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [3:0] rob);
        in_opcode = opc; in_precise = f3; in_more_precise = mp;
        in_value_1 = v1; in_value_2 = v2; in_value_pc = pc; in_imm = imm; in_rob_entry = rob;
        in_config = 1'b1;
    endtask

    task automatic run_op(input logic [6:0] opc, input logic [2:0] f3, input logic mp,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [3:0] rob);
        set_op(opc, f3, mp, v1, v2, pc, imm, rob);
        tick();
        in_config = 1'b0;
        tick();
    endtask

    task automatic rand_op();
        logic [6:0] opcs [8];
        opcs = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                 7'b1100011, 7'b0010011, 7'b0110011, 7'b0000000};
        in_opcode       = opcs[$urandom_range(0, 7)];
        in_precise      = 3'($urandom_range(0, 7));
        in_more_precise = 1'($urandom_range(0, 1));
        in_value_1      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
        in_value_2      = ($urandom_range(0, 3) == 0) ? in_value_1 : $urandom;
        in_value_pc     = $urandom;
        in_imm          = $urandom;
        in_rob_entry    = 4'($urandom_range(0, 15));
    endtask

    initial begin
        rst = 1; rdy = 1; rollback = 0; in_config = 0;
        in_value_1 = 0; in_value_2 = 0; in_value_pc = 0; in_imm = 0;
        in_opcode = 0; in_precise = 0; in_more_precise = 0; in_rob_entry = 0;
        pend_v = 0; pend = '0; exp_o = '0;
        @(negedge clk);
        tick();
        tick();
        rst = 0;

        // ADD: broadcast appears one edge after the S1 capture, not before
        set_op(7'b0110011, 3'd0, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0, 4'd3);
        tick();
        check_eq("t1_not_early", {31'd0, out_config}, 32'd0);
        in_config = 0;
        tick();
        check_eq("t1_cfg", {31'd0, out_config}, 32'd1);
        check_eq("t1_val", out_val, 32'd12);
        check_eq("t1_rob", {28'd0, out_rob_entry}, 32'd3);
        tick();
        check_eq("t1_single", {31'd0, out_config}, 32'd0);

        run_op(7'b0110011, 3'd0, 1'b1, 32'd3, 32'd5, 32'h0, 32'h0, 4'd1);
        check_eq("t2_sub", out_val, 32'hFFFF_FFFE);
        run_op(7'b0010011, 3'd5, 1'b1, 32'h8000_0000, 32'h0, 32'h0, 32'h404, 4'd2);
        check_eq("t2_srai", out_val, 32'hF800_0000);

        run_op(7'b1100011, 3'd4, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'hFFFF_FFF8, 4'd4);
        check_eq("t3_blt_taken", {31'd0, out_taken}, 32'd1);
        check_eq("t3_blt_tgt", out_target_pc, 32'hF8);
        run_op(7'b1100011, 3'd6, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'hFFFF_FFF8, 4'd5);
        check_eq("t3_bltu_taken", {31'd0, out_taken}, 32'd0);
        check_eq("t3_bltu_tgt", out_target_pc, 32'h104);

        run_op(7'b1100111, 3'd0, 1'b0, 32'h1001, 32'h0, 32'h40, 32'd2, 4'd6);
        check_eq("t4_val", out_val, 32'h44);
        check_eq("t4_tgt", out_target_pc, 32'h1002);
        check_eq("t4_br", {31'd0, out_is_branch}, 32'd1);

        // Rollback while the op sits in S1
        set_op(7'b0010011, 3'd0, 1'b0, 32'd1, 32'd0, 32'h0, 32'd1, 4'd7);
        tick();
        in_config = 0; rollback = 1;
        tick();
        rollback = 0;
        tick();
        check_eq("t5_s1_flush", {31'd0, out_config}, 32'd0);
        // Issue and rollback on the same edge
        set_op(7'b0010011, 3'd0, 1'b0, 32'd2, 32'd0, 32'h0, 32'd1, 4'd8);
        rollback = 1;
        tick();
        rollback = 0; in_config = 0;
        tick();
        check_eq("t5_same_edge", {31'd0, out_config}, 32'd0);
        // Rollback while the op is being broadcast, then reset with live data
        run_op(7'b0110111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h0, 32'hABCD_E000, 4'd9);
        rollback = 1;
        tick();
        rollback = 0;
        run_op(7'b1101111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h200, 32'h20, 4'd10);
        rst = 1;
        tick();
        rst = 0;
        check_eq("t5_rst_val", out_val, 32'd0);

        // rdy low with ops in S1 and S2; stray issues while stalled are ignored
        set_op(7'b0010111, 3'd0, 1'b0, 32'd0, 32'd0, 32'h1000, 32'h10, 4'd11);
        tick();
        set_op(7'b0110011, 3'd4, 1'b0, 32'hF0F0, 32'h0FF0, 32'h0, 32'h0, 4'd12);
        tick();
        rdy = 0;
        set_op(7'b0110011, 3'd6, 1'b0, 32'h1, 32'h2, 32'h0, 32'h0, 4'd13);
        repeat (3) tick();
        check_eq("t6_frozen_val", out_val, 32'h1010);
        rdy = 1; in_config = 0;
        tick();
        check_eq("t6_resume_val", out_val, 32'hFF00);
        tick();
        check_eq("t6_one_pulse", {31'd0, out_config}, 32'd0);

        // Back-to-back issue stream
        for (int unsigned i = 0; i < 6; i++) begin
            rand_op();
            in_config = 1;
            tick();
        end
        in_config = 0;
        tick();

        for (int unsigned i = 0; i < 3000; i++) begin
            rand_op();
            in_config = ($urandom_range(0, 9) < 7);
            rdy       = ($urandom_range(0, 9) < 8);
            rollback  = ($urandom_range(0, 19) == 0);
            rst       = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 0; rollback = 0; rdy = 1; in_config = 0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
